// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter: FSM states, default bus widths, request record.
// Pure declarations, no logic or timing.
package apb_arb_pkg;

  localparam int APB_AW_DEF = 32;
  localparam int APB_DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_AW_DEF-1:0] addr;
    logic [APB_DW_DEF-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: grant is combinational from the request vector and the owned pointer.
// The pointer moves past the winner only when the caller strobes i_advance.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win_idx;
  int            w_cand;

  // Scan offsets from the far end so the lowest offset from r_ptr wins last.
  always_comb begin
    o_grant   = '0;
    o_valid   = 1'b0;
    w_win_idx = '0;
    w_cand    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = (int'(r_ptr) + k >= NUM_REQ) ? int'(r_ptr) + k - NUM_REQ : int'(r_ptr) + k;
      if (i_req[w_cand]) begin
        o_valid   = 1'b1;
        w_win_idx = w_cand[PW-1:0];
      end
    end
    if (o_valid) o_grant[w_win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_valid) begin
      r_ptr <= (w_win_idx == PW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3 master among NUM_REQ requesters; grant -> SETUP -> ACCESS, rsp 1 cycle after pready.
// Requesters hold until req_ready; APB_TIMEOUT_EN adds a TIMEOUT_CYC wait-state limit with error completion.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int APB_AW      = APB_AW_DEF,
  parameter int APB_DW      = APB_DW_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*APB_AW-1:0] req_addr,
  input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [APB_DW-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_AW-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DW-1:0]         pwdata,
  input  logic [APB_DW-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } req_fields_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("apb_master_arbiter: unsupported parameter set");
  end

  apb_state_e         r_state;
  logic [NUM_REQ-1:0] r_owner;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_vld;
  logic               w_accept;
  req_fields_t        w_sel;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait_cnt;
`endif

  assign w_accept  = (r_state == IDLE) && !rst && w_grant_vld;
  assign req_ready = w_accept ? w_grant : '0;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_valid   (w_grant_vld)
  );

  // One-hot grant makes an OR-mux sufficient for field selection.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.write = w_sel.write | req_write[i];
        w_sel.addr  = w_sel.addr  | req_addr[i*APB_AW +: APB_AW];
        w_sel.wdata = w_sel.wdata | req_wdata[i*APB_DW +: APB_DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_state <= SETUP;
            r_owner <= w_grant;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= w_sel.write;
            paddr   <= w_sel.addr;
            pwdata  <= w_sel.wdata;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            r_state   <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= r_owner;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
          end
`ifdef APB_TIMEOUT_EN
          // The stall that would bring the count to TIMEOUT_CYC ends the transfer.
          else if (r_wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            r_state   <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= r_owner;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: protocol-level model checked every cycle plus literal pins.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the wait-state limit.
`timescale 1ns/1ps
module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .NUM_REQ(N), .APB_AW(AW), .APB_DW(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expected registered outputs for the current cycle, plus arbitration pointer.
  bit            mon_on = 1'b0;
  bit            e_psel = 1'b0, e_pen = 1'b0, e_pwrite = 1'b0, e_err = 1'b0;
  logic [AW-1:0] e_paddr = '0;
  logic [DW-1:0] e_pwdata = '0, e_rdata = '0;
  logic [N-1:0]  e_rsp_vld = '0;
  int            m_ptr = 0, m_owner = 0, m_wait = 0;

  // Trace for the literal checks.
  int            g_q[$];
  int            rsp_cnt = 0, cur_psel = 0, cur_pen = 0, last_psel = 0, last_pen = 0;
  logic [N-1:0]  last_vec = '0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  task automatic model_done(input logic [DW-1:0] rd, input bit er);
    e_psel    = 1'b0;
    e_pen     = 1'b0;
    e_rsp_vld = '0;
    e_rsp_vld[m_owner] = 1'b1;
    e_rdata   = rd;
    e_err     = er;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      int w;
      logic [N-1:0] exp_rdy;
      chk("psel", psel, e_psel);
      chk("penable", penable, e_pen);
      chk("paddr", paddr, e_paddr);
      chk("pwrite", pwrite, e_pwrite);
      chk("pwdata", pwdata, e_pwdata);
      chk("rsp_valid", rsp_valid, e_rsp_vld);
      if (e_rsp_vld != '0) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", rsp_err, e_err);
      end
      w = -1;
      if (!rst && !e_psel)
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);

      if (psel) cur_psel++;
      if (penable) cur_pen++;
      if (rsp_valid != '0) begin
        rsp_cnt++;
        last_psel  = cur_psel;
        last_pen   = cur_pen;
        last_vec   = rsp_valid;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
      for (int k = 0; k < N; k++) if (req_ready[k]) g_q.push_back(k);

      if (rst) begin
        e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0;
        e_rsp_vld = '0; e_rdata = '0; e_err = 0; m_ptr = 0;
      end else begin
        e_rsp_vld = '0;
        if (w >= 0) begin
          e_psel   = 1'b1;
          e_pen    = 1'b0;
          e_pwrite = req_write[w];
          e_paddr  = req_addr[w*AW +: AW];
          e_pwdata = req_wdata[w*DW +: DW];
          m_owner  = w;
          m_ptr    = (w + 1) % N;
          m_wait   = 0;
          cur_psel = 0;
          cur_pen  = 0;
        end else if (e_psel && !e_pen) begin
          e_pen = 1'b1;
        end else if (e_pen) begin
          if (pready) model_done(e_pwrite ? '0 : prdata, pslverr);
`ifdef APB_TIMEOUT_EN
          else begin
            m_wait++;
            if (m_wait == TO) model_done('0, 1'b1);
          end
`endif
        end
      end
    end
  end

  // Stimulus helpers: requesters drop valid after their accept, slave inserts wait_states.
  bit           auto_drop = 1'b1;
  int           wait_states = 0;
  int           acc_cnt = 0;
  logic [N-1:0] seen;

  task automatic tick();
    @(negedge clk);
    seen = req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~seen;
    if (psel && penable) begin
      pready = (acc_cnt >= wait_states);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
  endtask

  task automatic issue(input int i, input apb_req_t r);
    req_write[i]           = r.write;
    req_addr[i*AW +: AW]   = r.addr;
    req_wdata[i*DW +: DW]  = r.wdata;
    req_valid[i]           = 1'b1;
  endtask

  task automatic wait_rsp(input int budget);
    int start;
    start = rsp_cnt;
    for (int c = 0; c < budget && rsp_cnt == start; c++) tick();
    chk("rsp_within_budget", rsp_cnt != start, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick();
    mon_on = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_psel", psel, 1'b0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_rsp_valid", rsp_valid, 2'b00);

    // Single write, zero wait states.
    issue(0, '{write: 1'b1, addr: 32'h10, wdata: 32'hA5A5_0001});
    wait_rsp(20);
    chk("wr_psel_cycles", last_psel, 2);
    chk("wr_penable_cycles", last_pen, 1);
    chk("wr_rsp_vec", last_vec, 2'b01);
    chk("wr_rsp_err", last_err, 1'b0);
    chk("wr_paddr_hold", paddr, 32'h10);

    // Read with three wait states.
    wait_states = 3;
    prdata = 32'hDEAD_BEEF;
    issue(1, '{write: 1'b0, addr: 32'h24, wdata: 32'h0});
    wait_rsp(30);
    chk("rd_penable_cycles", last_pen, 4);
    chk("rd_psel_cycles", last_psel, 5);
    chk("rd_rsp_vec", last_vec, 2'b10);
    chk("rd_rdata", last_rdata, 32'hDEAD_BEEF);

    // Both requesters held valid: alternating grants.
    wait_states = 0;
    auto_drop = 1'b0;
    g_q.delete();
    issue(0, '{write: 1'b1, addr: 32'h100, wdata: 32'h1111_0000});
    issue(1, '{write: 1'b1, addr: 32'h200, wdata: 32'h2222_0000});
    for (int t = 0; t < 4; t++) wait_rsp(20);
    req_valid = '0;
    auto_drop = 1'b1;
    wait_rsp(20);
    chk("rr_grant_count", g_q.size() >= 4, 1'b1);
    if (g_q.size() >= 4) begin
      chk("rr_grant0", g_q[0], 0);
      chk("rr_grant1", g_q[1], 1);
      chk("rr_grant2", g_q[2], 0);
      chk("rr_grant3", g_q[3], 1);
    end

    // Slave error, then a clean transfer.
    pslverr = 1'b1;
    issue(0, '{write: 1'b1, addr: 32'h30, wdata: 32'h3333_3333});
    wait_rsp(20);
    chk("slverr_err", last_err, 1'b1);
    pslverr = 1'b0;
    issue(1, '{write: 1'b1, addr: 32'h34, wdata: 32'h4444_4444});
    wait_rsp(20);
    chk("after_err_err", last_err, 1'b0);
    chk("after_err_vec", last_vec, 2'b10);

    // Reset in ACCESS aborts the transfer and returns the pointer to requester 0.
    wait_states = 1000;
    issue(0, '{write: 1'b0, addr: 32'h40, wdata: 32'h0});
    for (int c = 0; c < 20 && !penable; c++) tick();
    chk("abort_reached_access", penable, 1'b1);
    begin
      int cnt_before;
      cnt_before = rsp_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_psel", psel, 1'b0);
      chk("abort_penable", penable, 1'b0);
      tick();
      chk("abort_no_rsp", rsp_cnt, cnt_before);
    end
    wait_states = 0;
    g_q.delete();
    issue(1, '{write: 1'b1, addr: 32'h54, wdata: 32'h5555_0001});
    issue(0, '{write: 1'b1, addr: 32'h50, wdata: 32'h5555_0000});
    wait_rsp(20);
    wait_rsp(20);
    chk("post_reset_count", g_q.size() >= 2, 1'b1);
    if (g_q.size() >= 2) begin
      chk("post_reset_first", g_q[0], 0);
      chk("post_reset_second", g_q[1], 1);
    end

`ifdef APB_TIMEOUT_EN
    wait_states = 1000;
    prdata = 32'h1234_5678;
    issue(1, '{write: 1'b0, addr: 32'h60, wdata: 32'h0});
    wait_rsp(50);
    chk("to_penable_cycles", last_pen, TO);
    chk("to_err", last_err, 1'b1);
    chk("to_rdata", last_rdata, 32'h0);
    chk("to_psel_dropped", psel, 1'b0);
    wait_states = 0;
`endif

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB3 master port among NUM_REQ requesters (sensor config engine, debug path, DMA). It arbitrates round-robin, sequences the APB SETUP/ACCESS phases, honours pready wait states and returns prdata/pslverr to the winning requester. It drives the APB bus signals that the team's APB interface bundles.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
APB_AW, 32, address width
APB_DW, 32, data width
TIMEOUT_CYC, 256, ACCESS-phase wait-state limit (used only with APB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester transfer request
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*APB_AW  flattened addresses, requester i at [i*APB_AW +: APB_AW]
req_wdata  in  NUM_REQ*APB_DW  flattened write data
req_ready  out  NUM_REQ  one-hot grant/accept pulse
rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse
rsp_rdata  out  APB_DW  read data, valid with rsp_valid
rsp_err  out  1  pslverr (or timeout), valid with rsp_valid
paddr  out  APB_AW  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  APB_DW  APB write data
prdata  in  APB_DW  slave read data
pready  in  1  slave ready
pslverr  in  1  slave error

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; psel, penable, pwrite = 0; paddr, pwdata = 0; req_ready, rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; round-robin pointer = 0 (requester 0 has highest priority first). Reset mid-transfer aborts immediately. No rsp_valid is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is set, the arbiter picks the winner. req_ready[winner] pulses for 1 cycle and the winner's write/addr/wdata are registered. Next state is SETUP. Otherwise the FSM stays in IDLE with psel=0.
- SETUP: psel=1, penable=0, bus fields come from the captured values. Always lasts exactly 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1, bus fields held stable.
  - If pready=0: stay in ACCESS.
  - If pready=1: rsp_valid[winner]=1 next cycle; rsp_rdata = prdata for reads, 0 for writes; rsp_err = pslverr. psel and penable drop to 0. Next state is IDLE.
- No back-to-back SETUP: minimum transfer is 3 cycles (IDLE grant, SETUP, ACCESS). rsp_valid appears 1 cycle after the pready sample.
- Arbitration is round-robin. The search starts at pointer and wraps modulo NUM_REQ. After a grant, pointer = winner+1, wrapping from NUM_REQ-1 to 0.
- A requester must hold req_valid and its fields until req_ready. Fields are sampled only on req_ready, so changes afterwards are ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid asserted and win on later rounds. No requester waits more than NUM_REQ-1 transfers.
- Dropping req_valid before grant withdraws the request without penalty.
- A new req_valid from the same requester in the cycle of its rsp_valid is legal. The FSM is back in IDLE that cycle and arbitrates normally.
- Between transfers, paddr/pwrite/pwdata hold their last values; only psel/penable return to 0.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined: a wait counter is cleared on SETUP and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYC, the transfer completes with rsp_err=1 and rsp_rdata=0, and the FSM returns to IDLE (psel=0, penable=0).
- Undefined: no counter and no TIMEOUT_CYC logic. ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_arb_pkg:
  - typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS}
  - default APB_AW/APB_DW constants
  - typedef struct apb_req_t {write, addr, wdata}
- Sub-module apb_rr_arbiter (parameter NUM_REQ): inputs req vector, pointer and an advance strobe; outputs a one-hot grant and a valid flag. It owns the pointer register and its reset.

Test Plan:
- Single write from req0 (addr 0x10, data 0xA5A5_0001), pready tied 1 -> psel high 2 cycles, penable in cycle 2 only, rsp_valid[0] 1 cycle later, rsp_err=0.
- Read from req1 with pready low 3 ACCESS cycles, prdata=0xDEAD_BEEF -> ACCESS lasts 4 cycles, bus fields stable throughout, rsp_rdata=0xDEAD_BEEF, rsp_valid[1] only.
- req0 and req1 held valid continuously for 4 transfers -> grant order 0,1,0,1; never two req_ready bits high at once.
- Slave returns pslverr=1 on a write -> rsp_err=1 with rsp_valid. The next transfer proceeds normally with rsp_err=0.
- rst asserted during ACCESS -> next cycle psel=penable=0, state IDLE, no rsp_valid. The arbiter pointer is back to 0, so req0 wins first afterwards.
- With APB_TIMEOUT_EN, TIMEOUT_CYC=8, pready stuck 0 -> completion at wait count 8 with rsp_err=1, rsp_rdata=0, psel dropped.
